// File: rtl/riscv_alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Stage E holds the granted operation and drives the external ALU.
// Stage R captures the ALU result and presents it as the response.
module riscv_alu_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_r,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  localparam logic PRIO_INIT = (RR_INIT != 0);
  localparam logic [3:0] OP_MAX = 4'd9;

  logic        e_valid;
  logic        e_id;
  logic        e_err;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic [3:0]  e_op;

  logic        r_valid;
  logic        r_id;
  logic        r_err;
  logic [31:0] r_data;

  logic        prio;
  logic        r_adv;
  logic        e_adv;
  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic        win;

  // Pipeline advance conditions, arbitration and combinational ready.
  // Ready is masked by rst_n because the cleared pipeline would otherwise
  // report space while reset is still asserted.
  always_comb begin
    r_adv      = !r_valid || rsp_ready;
    e_adv      = !e_valid || r_adv;
    grant0     = req0_valid && (!req1_valid || !prio);
    grant1     = req1_valid && (!req0_valid || prio);
    req0_ready = grant0 && e_adv && rst_n;
    req1_ready = grant1 && e_adv && rst_n;
    xfer       = req0_ready || req1_ready;
    win        = req1_ready;
  end

  // Issue stage and round-robin priority: the winner hands priority to the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_id    <= 1'b0;
      e_err   <= 1'b0;
      e_a     <= '0;
      e_b     <= '0;
      e_op    <= '0;
      prio    <= PRIO_INIT;
    end else if (xfer) begin
      e_valid <= 1'b1;
      e_id    <= win;
      e_a     <= win ? req1_a : req0_a;
      e_b     <= win ? req1_b : req0_b;
      e_op    <= win ? req1_op : req0_op;
      e_err   <= (win ? req1_op : req0_op) > OP_MAX;
      prio    <= !win;
    end else if (e_adv) begin
      e_valid <= 1'b0;
    end
  end

  // Result stage: captures the ALU output, forcing zero data for illegal opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_id    <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else if (r_adv) begin
      r_valid <= e_valid;
      r_id    <= e_id;
      r_err   <= e_err;
      r_data  <= e_err ? '0 : alu_r;
    end
  end

  // ALU operands come straight from E; illegal opcodes present ADD to the ALU.
  always_comb begin
    alu_a  = e_a;
    alu_b  = e_b;
    alu_op = e_err ? '0 : e_op;
  end

  // Response interface mirrors the R stage.
  always_comb begin
    rsp_valid = r_valid;
    rsp_id    = r_id;
    rsp_data  = r_data;
    rsp_err   = r_err;
  end

endmodule
